spi_text_cmd_decoder: RTL and testbench
=======================================

Name: spi_text_cmd_decoder

Overview:
Consumes bytes from the SPI slave receiver (byte value plus level "done" flag) and interprets them as text-mode commands. Drives the write port of the VGA character RAM: set cursor, write character, set attribute, clear screen. Sits between the SPI receiver and the dual-port text buffer read by the VGA scan-out logic.

Parameters:
COLS, 80, characters per row
ROWS, 30, character rows
ADDR_W, 12, RAM address width (must satisfy 2^ADDR_W >= COLS*ROWS)
ATTR_RESET, 8'h0F, attribute value after reset

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
spi_byte  in  8  last received SPI byte, stable while spi_done is high
spi_done  in  1  level, high once 8 bits are received; a new byte is marked by its 0->1 edge
spi_cs  in  1  synchronized chip select, active-low
ram_addr  out  ADDR_W  character RAM write address
ram_wdata  out  16  {attr[7:0], char[7:0]}
ram_we  out  1  single-cycle write strobe
busy  out  1  high while a clear is in progress
cursor_row  out  5  current row
cursor_col  out  7  current column
cmd_error  out  1  sticky: bad opcode or out-of-range cursor
overrun  out  1  sticky: byte dropped while busy

Behaviour:
- Reset values: ram_addr=0, ram_wdata=0, ram_we=0, busy=0, cursor=(0,0), cmd_error=0, overrun=0, attr=ATTR_RESET, state=IDLE.
- A byte strobe fires in any cycle where spi_done=1 and the registered previous value of spi_done=0.
- A frame end fires on a 0->1 edge of spi_cs, detected against its registered previous value.
- Opcodes, taken in IDLE:
  - 0x01 SET_CURSOR: goes to ARG_ROW, then ARG_COL.
  - 0x02 WRITE_CHAR: goes to ARG_CHAR.
  - 0x03 CLEAR: goes to CLEARING.
  - 0x04 SET_ATTR: goes to ARG_ATTR.
  - Any other value: sets cmd_error and stays in IDLE.
- ARG_ROW: latches the row and goes to ARG_COL.
- ARG_COL:
  - If row<ROWS and col<COLS: cursor takes the new position.
  - Otherwise: cursor unchanged and cmd_error set.
  - Either way, returns to IDLE.
- ARG_CHAR, registered outputs on the cycle after the strobe:
  - ram_we=1 for one cycle.
  - ram_addr = row*COLS+col.
  - ram_wdata = {attr, byte}.
  - The same cycle, the cursor advances: col+1; at col=COLS-1, col=0 and row+1; at (ROWS-1, COLS-1), the cursor wraps to (0,0). Returns to IDLE.
- ARG_ATTR: attr=byte, then IDLE. Already-written cells are not modified.
- CLEARING:
  - busy=1 from the cycle after the opcode strobe.
  - One write per cycle, ram_addr 0..COLS*ROWS-1, ram_wdata={attr,8'h20}.
  - busy deasserts and the cursor goes to (0,0) the cycle after the last write.
  - Exactly COLS*ROWS ram_we pulses.
- Strobe while CLEARING: byte dropped, overrun=1. Clear continues.
- Frame end in any ARG_* state aborts to IDLE with no write. Frame end does not abort CLEARING.
- Strobe and frame end in the same cycle: the frame end wins and the byte is dropped.
- rst mid-clear: immediate return to reset values. RAM contents are not restored.
- cmd_error and overrun are cleared only by rst.
- Address arithmetic is done at ADDR_W width. No multiplier is needed: the linear address is tracked incrementally alongside row/col, and recomputed on SET_CURSOR.

Decomposition:
- Package spi_text_pkg holds:
  - opcode localparams OP_SET_CURSOR, OP_WRITE_CHAR, OP_CLEAR, OP_SET_ATTR;
  - space char 8'h20;
  - state encoding IDLE, ARG_ROW, ARG_COL, ARG_CHAR, ARG_ATTR, CLEARING.
- Sub-module text_cursor holds row/col/linear-address registers with load, advance/wrap and zero operations. It is reused by any future scroll logic.

Test Plan:
- Bytes 0x04,0x1E then 0x02,0x41 -> one ram_we, addr 0, wdata 16'h1E41, cursor (0,1).
- 0x01,0x1D,0x4F then 0x02,0x5A -> write at addr 2399, wdata {0x0F,0x5A}, cursor wraps to (0,0).
- 0x03, then 2 bytes sent during clear -> 2400 consecutive ram_we pulses, addr 0..2399, wdata 16'h0F20, busy high exactly 2400 cycles, overrun=1, cursor (0,0).
- 0x01,0x1E,0x00 -> cmd_error=1, cursor unchanged. Then 0x7F -> no write, cmd_error stays 1.
- 0x02 then spi_cs rises before the char byte; next frame 0x02,0x42 -> no write from the aborted frame, one write of 0x42 at the cursor.
- rst asserted 100 cycles into a clear -> next cycle busy=0, ram_we=0, cursor (0,0), flags 0; a following 0x02,0x43 writes addr 0.

Source files
------------

// File: rtl/spi_text_pkg.sv
// Shared opcodes, state encoding and helpers for the SPI text-mode
// command decoder.
package spi_text_pkg;

  localparam logic [7:0] OP_SET_CURSOR = 8'h01;
  localparam logic [7:0] OP_WRITE_CHAR = 8'h02;
  localparam logic [7:0] OP_CLEAR      = 8'h03;
  localparam logic [7:0] OP_SET_ATTR   = 8'h04;
  localparam logic [7:0] CHAR_SPACE    = 8'h20;

  typedef enum logic [2:0] {
    IDLE,
    ARG_ROW,
    ARG_COL,
    ARG_CHAR,
    ARG_ATTR,
    CLEARING
  } state_e;

  // Shift-add form of row*cols; cols is a constant so this folds
  // down to a few adders.
  function automatic logic [15:0] row_base(
    input logic [4:0]  row,
    input logic [15:0] cols
  );
    logic [15:0] acc;
    acc = '0;
    for (int i = 0; i < 5; i++) begin
      if (row[i]) acc = acc + (cols << i);
    end
    return acc;
  endfunction

endpackage

// File: rtl/text_cursor.sv
// Text cursor: row/col plus the matching linear cell address,
// with load, advance-with-wrap and zero operations.
module text_cursor
  import spi_text_pkg::*;
#(
  parameter int COLS   = 80,
  parameter int ROWS   = 30,
  parameter int ADDR_W = 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_i,
  input  logic              adv_i,
  input  logic              zero_i,
  input  logic [4:0]        row_i,
  input  logic [6:0]        col_i,
  output logic [4:0]        row_o,
  output logic [6:0]        col_o,
  output logic [ADDR_W-1:0] lin_o
);

  localparam logic [4:0]  ROW_MAX = 5'(ROWS - 1);
  localparam logic [6:0]  COL_MAX = 7'(COLS - 1);
  localparam logic [15:0] COLS_W  = 16'(COLS);

  logic [4:0]        row_q, row_d;
  logic [6:0]        col_q, col_d;
  logic [ADDR_W-1:0] lin_q, lin_d;

  always_comb begin
    row_d = row_q;
    col_d = col_q;
    lin_d = lin_q;
    unique case (1'b1)
      zero_i: begin
        row_d = '0;
        col_d = '0;
        lin_d = '0;
      end
      load_i: begin
        row_d = row_i;
        col_d = col_i;
        lin_d = ADDR_W'(row_base(row_i, COLS_W))
              + ADDR_W'(col_i);
      end
      adv_i: begin
        if (col_q == COL_MAX) begin
          col_d = '0;
          if (row_q == ROW_MAX) begin
            row_d = '0;
            lin_d = '0;
          end else begin
            row_d = row_q + 5'd1;
            lin_d = lin_q + ADDR_W'(1);
          end
        end else begin
          col_d = col_q + 7'd1;
          lin_d = lin_q + ADDR_W'(1);
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      row_q <= '0;
      col_q <= '0;
      lin_q <= '0;
    end else begin
      row_q <= row_d;
      col_q <= col_d;
      lin_q <= lin_d;
    end
  end

  assign row_o = row_q;
  assign col_o = col_q;
  assign lin_o = lin_q;

endmodule

// File: rtl/spi_text_cmd_decoder.sv
// Turns SPI bytes into text-mode commands driving the write port
// of the VGA character RAM.
module spi_text_cmd_decoder
  import spi_text_pkg::*;
#(
  parameter int         COLS       = 80,
  parameter int         ROWS       = 30,
  parameter int         ADDR_W     = 12,
  parameter logic [7:0] ATTR_RESET = 8'h0F
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        spi_byte,
  input  logic              spi_done,
  input  logic              spi_cs,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [15:0]       ram_wdata,
  output logic              ram_we,
  output logic              busy,
  output logic [4:0]        cursor_row,
  output logic [6:0]        cursor_col,
  output logic              cmd_error,
  output logic              overrun
);

  localparam int         CW     = ADDR_W + 1;
  localparam logic [CW-1:0] CELLS = CW'(COLS * ROWS);
  localparam logic [7:0] ROWS_B = 8'(ROWS);
  localparam logic [7:0] COLS_B = 8'(COLS);

  state_e            state_q, state_d;
  logic              done_q, cs_q;
  logic [7:0]        attr_q, attr_d;
  logic [7:0]        rarg_q, rarg_d;
  logic [CW-1:0]     clr_q, clr_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [15:0]       wdata_q, wdata_d;
  logic              we_q, we_d;
  logic              busy_q, busy_d;
  logic              err_q, err_d;
  logic              ovr_q, ovr_d;

  logic              strobe, fend, take;
  logic              cur_load, cur_adv, cur_zero;
  logic [ADDR_W-1:0] cur_lin;

  assign strobe = spi_done & ~done_q;
  assign fend   = spi_cs & ~cs_q;
  assign take   = strobe & ~fend;

  text_cursor #(
    .COLS   (COLS),
    .ROWS   (ROWS),
    .ADDR_W (ADDR_W)
  ) u_cursor (
    .clk    (clk),
    .rst    (rst),
    .load_i (cur_load),
    .adv_i  (cur_adv),
    .zero_i (cur_zero),
    .row_i  (rarg_q[4:0]),
    .col_i  (spi_byte[6:0]),
    .row_o  (cursor_row),
    .col_o  (cursor_col),
    .lin_o  (cur_lin)
  );

  always_comb begin
    state_d  = state_q;
    attr_d   = attr_q;
    rarg_d   = rarg_q;
    clr_d    = clr_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    we_d     = 1'b0;
    busy_d   = busy_q;
    err_d    = err_q;
    ovr_d    = ovr_q;
    cur_load = 1'b0;
    cur_adv  = 1'b0;
    cur_zero = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (take) begin
          unique case (spi_byte)
            OP_SET_CURSOR: state_d = ARG_ROW;
            OP_WRITE_CHAR: state_d = ARG_CHAR;
            OP_SET_ATTR:   state_d = ARG_ATTR;
            OP_CLEAR: begin
              // first cell is written now so busy spans
              // exactly one cycle per cell
              state_d = CLEARING;
              we_d    = 1'b1;
              addr_d  = '0;
              wdata_d = {attr_q, CHAR_SPACE};
              busy_d  = 1'b1;
              clr_d   = CW'(1);
            end
            default: err_d = 1'b1;
          endcase
        end
      end
      ARG_ROW: begin
        if (fend) begin
          state_d = IDLE;
        end else if (strobe) begin
          rarg_d  = spi_byte;
          state_d = ARG_COL;
        end
      end
      ARG_COL: begin
        if (fend) begin
          state_d = IDLE;
        end else if (strobe) begin
          if (rarg_q < ROWS_B && spi_byte < COLS_B) begin
            cur_load = 1'b1;
          end else begin
            err_d = 1'b1;
          end
          state_d = IDLE;
        end
      end
      ARG_CHAR: begin
        if (fend) begin
          state_d = IDLE;
        end else if (strobe) begin
          we_d    = 1'b1;
          addr_d  = cur_lin;
          wdata_d = {attr_q, spi_byte};
          cur_adv = 1'b1;
          state_d = IDLE;
        end
      end
      ARG_ATTR: begin
        if (fend) begin
          state_d = IDLE;
        end else if (strobe) begin
          attr_d  = spi_byte;
          state_d = IDLE;
        end
      end
      CLEARING: begin
        if (strobe) ovr_d = 1'b1;
        if (clr_q == CELLS) begin
          busy_d   = 1'b0;
          cur_zero = 1'b1;
          state_d  = IDLE;
        end else begin
          we_d    = 1'b1;
          addr_d  = clr_q[ADDR_W-1:0];
          wdata_d = {attr_q, CHAR_SPACE};
          clr_d   = clr_q + CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      done_q  <= 1'b0;
      cs_q    <= 1'b1;
      attr_q  <= ATTR_RESET;
      rarg_q  <= '0;
      clr_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= spi_done;
      cs_q    <= spi_cs;
      attr_q  <= attr_d;
      rarg_q  <= rarg_d;
      clr_q   <= clr_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      we_q    <= we_d;
      busy_q  <= busy_d;
      err_q   <= err_d;
      ovr_q   <= ovr_d;
    end
  end

  assign ram_addr  = addr_q;
  assign ram_wdata = wdata_q;
  assign ram_we    = we_q;
  assign busy      = busy_q;
  assign cmd_error = err_q;
  assign overrun   = ovr_q;

endmodule

// File: tb/tb_spi_text_cmd_decoder.sv
// Scoreboard bench for spi_text_cmd_decoder against a byte-level
// command model.
module tb_spi_text_cmd_decoder;

  localparam int COLS  = 80;
  localparam int ROWS  = 30;
  localparam int CELLS = COLS * ROWS;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  spi_byte = '0;
  logic        spi_done = 1'b0;
  logic        spi_cs = 1'b1;
  logic [11:0] ram_addr;
  logic [15:0] ram_wdata;
  logic        ram_we;
  logic        busy;
  logic [4:0]  cursor_row;
  logic [6:0]  cursor_col;
  logic        cmd_error;
  logic        overrun;

  spi_text_cmd_decoder dut (
    .clk        (clk),
    .rst        (rst),
    .spi_byte   (spi_byte),
    .spi_done   (spi_done),
    .spi_cs     (spi_cs),
    .ram_addr   (ram_addr),
    .ram_wdata  (ram_wdata),
    .ram_we     (ram_we),
    .busy       (busy),
    .cursor_row (cursor_row),
    .cursor_col (cursor_col),
    .cmd_error  (cmd_error),
    .overrun    (overrun)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int busy_cnt = 0;

  logic [27:0] exp_q[$];
  logic [7:0]  cur[$];
  int m_row, m_col, m_attr;
  bit m_err, m_ovr, m_busy;

  task automatic chk(string name, int act, int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (busy) busy_cnt++;
    if (ram_we) begin
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_write: got addr %0h data %0h expected none",
                 ram_addr, ram_wdata);
      end else begin
        logic [27:0] e;
        e = exp_q.pop_front();
        chk("ram_addr", int'(ram_addr), int'(e[27:16]));
        chk("ram_wdata", int'(ram_wdata), int'(e[15:0]));
      end
    end
  end

  task automatic model_reset();
    m_row = 0; m_col = 0; m_attr = 8'h0F;
    m_err = 0; m_ovr = 0; m_busy = 0;
    cur.delete();
  endtask

  task automatic model_byte(logic [7:0] b);
    int lin;
    if (m_busy) begin
      m_ovr = 1;
      return;
    end
    cur.push_back(b);
    case (cur[0])
      8'h01: if (cur.size() == 3) begin
        if (cur[1] < ROWS && cur[2] < COLS) begin
          m_row = cur[1];
          m_col = cur[2];
        end else m_err = 1;
        cur.delete();
      end
      8'h02: if (cur.size() == 2) begin
        lin = m_row * COLS + m_col;
        exp_q.push_back({12'(lin), 8'(m_attr), cur[1]});
        lin = (lin + 1) % CELLS;
        m_row = lin / COLS;
        m_col = lin % COLS;
        cur.delete();
      end
      8'h03: begin
        for (int a = 0; a < CELLS; a++)
          exp_q.push_back({12'(a), 8'(m_attr), 8'h20});
        m_row = 0; m_col = 0; m_busy = 1;
        cur.delete();
      end
      8'h04: if (cur.size() == 2) begin
        m_attr = cur[1];
        cur.delete();
      end
      default: begin
        m_err = 1;
        cur.delete();
      end
    endcase
  endtask

  task automatic send_byte(logic [7:0] b);
    model_byte(b);
    @(posedge clk); #1;
    spi_byte = b;
    spi_done = 1'b1;
    repeat (2) @(posedge clk);
    #1 spi_done = 1'b0;
    @(posedge clk);
  endtask

  task automatic frame_end();
    @(posedge clk); #1 spi_cs = 1'b1;
    cur.delete();
    @(posedge clk); #1 spi_cs = 1'b0;
    @(posedge clk);
  endtask

  task automatic check_state(string tag);
    @(negedge clk);
    chk({tag, "_row"}, int'(cursor_row), m_row);
    chk({tag, "_col"}, int'(cursor_col), m_col);
    chk({tag, "_err"}, int'(cmd_error), int'(m_err));
    chk({tag, "_ovr"}, int'(overrun), int'(m_ovr));
  endtask

  task automatic wait_idle();
    for (int i = 0; i < CELLS + 500; i++) begin
      @(negedge clk);
      if (!busy) break;
    end
    chk("clear_done", int'(busy), 0);
    m_busy = 0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    model_reset();
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_addr", int'(ram_addr), 0);
    chk("rst_wdata", int'(ram_wdata), 0);
    chk("rst_we", int'(ram_we), 0);
    chk("rst_busy", int'(busy), 0);
    check_state("rst");
    @(posedge clk); #1 spi_cs = 1'b0;

    send_byte(8'h04); send_byte(8'h1E);
    send_byte(8'h02); send_byte(8'h41);
    check_state("wr_first");
    chk("wr_first_col", int'(cursor_col), 1);

    send_byte(8'h01); send_byte(8'h1D); send_byte(8'h4F);
    send_byte(8'h04); send_byte(8'h0F);
    send_byte(8'h02); send_byte(8'h5A);
    check_state("wr_wrap");

    busy_cnt = 0;
    send_byte(8'h03);
    send_byte(8'h55); send_byte(8'h66);
    wait_idle();
    chk("clear_busy_cycles", busy_cnt, CELLS);
    chk("clear_all_written", exp_q.size(), 0);
    check_state("clear");

    send_byte(8'h01); send_byte(8'h1E); send_byte(8'h00);
    check_state("bad_row");
    send_byte(8'h7F);
    check_state("bad_op");

    send_byte(8'h02);
    frame_end();
    send_byte(8'h02); send_byte(8'h42);
    check_state("abort");

    for (int n = 0; n < 300; n++) begin
      int kind;
      kind = $urandom_range(0, 4);
      case (kind)
        0: begin
          send_byte(8'h01);
          send_byte(8'($urandom_range(0, 33)));
          send_byte(8'($urandom_range(0, 84)));
        end
        1: begin
          send_byte(8'h02);
          send_byte(8'($urandom_range(0, 255)));
        end
        2: begin
          send_byte(8'h04);
          send_byte(8'($urandom_range(0, 255)));
        end
        3: send_byte(8'($urandom_range(5, 255)));
        default: begin
          send_byte(8'($urandom_range(1, 2)));
          if ($urandom_range(0, 1) == 1)
            send_byte(8'($urandom_range(0, 20)));
          frame_end();
        end
      endcase
      if (n % 25 == 24) check_state("rand");
    end
    check_state("rand_end");

    send_byte(8'h03);
    repeat (100) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    exp_q.delete();
    model_reset();
    @(negedge clk);
    chk("midrst_busy", int'(busy), 0);
    chk("midrst_we", int'(ram_we), 0);
    check_state("midrst");

    send_byte(8'h02); send_byte(8'h43);
    check_state("post_rst");
    repeat (5) @(posedge clk);
    chk("final_queue_empty", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
